dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dma_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// Round-robin DMA arbiter: picks one of N requesters, negotiates the bus with the
// processor board, steers address/strobe/ack to the owner and polices tenure length.
module dma_arbiter #(
  parameter int N      = 4,
  parameter int MAXCYC = 1024
) (
  input  logic            clk_p,
  input  logic            rst_n,
  input  logic [N-1:0]    dev_req,
  input  logic [18*N-1:0] dev_adr18,
  input  logic [N-1:0]    dev_stb,
  output logic [N-1:0]    dev_gnt,
  output logic [N-1:0]    dev_ack,
  output logic            dma_req,
  input  logic            dma_ack,
  output logic [17:0]     dma_adr18,
  output logic            dma_stb,
  input  logic            mem_ack,
  output logic [2:0]      owner,
  output logic            overrun,
  input  logic            ovr_clr,
  output logic [1:0]      dbg_state
);

  localparam int TW = $clog2(MAXCYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_GRANT = 2'd2,
    S_REL   = 2'd3
  } state_t;

  // Handshake: dma_req is held high from arbitration until the grant ends or
  // the winner withdraws; the board owns the bus while dma_ack is high and the
  // arbiter only returns to IDLE once dma_ack has been released.
  state_t         state_q, state_d;
  logic [2:0]     winner_q, winner_d;
  logic [2:0]     rr_q, rr_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           dma_req_q, dma_req_d;
  logic [2:0]     owner_q, owner_d;
  logic           ovr_q, ovr_d;
  logic [TW-1:0]  tenure_q, tenure_d;

  logic [2:0]     pick;
  int             off;
  int             best;
  logic           req_w;
  logic           stb_w;
  logic [17:0]    adr_w;
  logic [N-1:0]   win_onehot;
  logic [2:0]     rr_next;
  logic           ovr_set;
  logic           in_grant;

  // Winner search: smallest circular distance upward from the rr pointer.
  always_comb begin
    pick = '0;
    best = N;
    off  = 0;
    for (int k = 0; k < N; k++) begin
      off = k - int'(rr_q);
      if (off < 0) off = off + N;
      if (dev_req[k] && (off < best)) begin
        best = off;
        pick = 3'(k);
      end
    end
  end

  always_comb begin
    req_w      = 1'b0;
    stb_w      = 1'b0;
    adr_w      = '0;
    win_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (winner_q == 3'(k)) begin
        req_w         = dev_req[k];
        stb_w         = dev_stb[k];
        adr_w         = dev_adr18[18*k +: 18];
        win_onehot[k] = 1'b1;
      end
    end
  end

  assign rr_next = (winner_q == 3'(N-1)) ? 3'd0 : winner_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    dma_req_d = dma_req_q;
    owner_d   = owner_q;
    tenure_d  = tenure_q;
    ovr_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|dev_req) begin
          winner_d  = pick;
          dma_req_d = 1'b1;
          state_d   = S_ARB;
        end
      end
      S_ARB: begin
        if (!req_w) begin
          dma_req_d = 1'b0;
          state_d   = S_REL;
        end else if (dma_ack) begin
          gnt_d    = win_onehot;
          owner_d  = winner_q;
          tenure_d = '0;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (tenure_q != TW'(MAXCYC)) tenure_d = tenure_q + TW'(1);
        // Overrun fires once, on the cycle the counter reaches its limit.
        if (tenure_q == TW'(MAXCYC - 1)) ovr_set = 1'b1;
        if (!req_w) begin
          gnt_d     = '0;
          dma_req_d = 1'b0;
          rr_d      = rr_next;
          state_d   = S_REL;
        end else if (!dma_ack) begin
          gnt_d     = '0;
          dma_req_d = 1'b0;
          rr_d      = rr_next;
          ovr_set   = 1'b1;
          state_d   = S_REL;
        end
      end
      S_REL: begin
        if (!dma_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ovr_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      winner_q  <= '0;
      rr_q      <= '0;
      gnt_q     <= '0;
      dma_req_q <= 1'b0;
      owner_q   <= '0;
      ovr_q     <= 1'b0;
      tenure_q  <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      dma_req_q <= dma_req_d;
      owner_q   <= owner_d;
      ovr_q     <= ovr_d;
      tenure_q  <= tenure_d;
    end
  end

  assign in_grant  = (state_q == S_GRANT);
  assign dma_adr18 = in_grant ? adr_w : 18'd0;
  assign dma_stb   = in_grant & stb_w;
  assign dev_ack   = (in_grant && mem_ack) ? gnt_q : '0;

  assign dev_gnt   = gnt_q;
  assign dma_req   = dma_req_q;
  assign owner     = owner_q;
  assign overrun   = ovr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Bench for dma_arbiter: cycle-vector table, hand-written corner sequences and a
// randomized run scored against a transaction-level round-robin model.
module tb_dma_arbiter;

  localparam int N = 4;

  logic            clk_p = 1'b0;
  logic            rst_n;
  logic [N-1:0]    dev_req;
  logic [18*N-1:0] dev_adr18;
  logic [N-1:0]    dev_stb;
  logic [N-1:0]    dev_gnt;
  logic [N-1:0]    dev_ack;
  logic            dma_req;
  logic            dma_ack;
  logic [17:0]     dma_adr18;
  logic            dma_stb;
  logic            mem_ack;
  logic [2:0]      owner;
  logic            overrun;
  logic            ovr_clr;
  logic [1:0]      dbg_state;

  logic [17:0]     adr_arr[N];

  for (genvar g = 0; g < N; g++) begin : g_adr
    assign dev_adr18[18*g +: 18] = adr_arr[g];
  end

  dma_arbiter #(.N(N), .MAXCYC(16)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .dev_req(dev_req), .dev_adr18(dev_adr18),
    .dev_stb(dev_stb), .dev_gnt(dev_gnt), .dev_ack(dev_ack), .dma_req(dma_req),
    .dma_ack(dma_ack), .dma_adr18(dma_adr18), .dma_stb(dma_stb), .mem_ack(mem_ack),
    .owner(owner), .overrun(overrun), .ovr_clr(ovr_clr), .dbg_state(dbg_state)
  );

  always #5 clk_p = ~clk_p;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic       mem;
    logic [3:0] e_gnt;
    logic       e_dreq;
    logic [2:0] e_own;
    logic [3:0] e_dack;
    logic       e_stb;
  } vec_t;

  vec_t vt[$];
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  function automatic logic [17:0] adr_of(input int k);
    return 18'(32'h2_0000 + k * 32'h0111 + 32'h5A);
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic a, input logic m,
                              input logic [3:0] g, input logic d, input logic [2:0] o,
                              input logic [3:0] da, input logic s);
    vec_t v;
    v.rst_n = r; v.req = q; v.ack = a; v.mem = m;
    v.e_gnt = g; v.e_dreq = d; v.e_own = o; v.e_dack = da; v.e_stb = s;
    return v;
  endfunction

  function automatic logic [3:0] onehot(input logic [2:0] w);
    logic [3:0] r;
    r = 4'b0001 << w;
    return r;
  endfunction

  function automatic logic [2:0] gidx(input logic [3:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 0; k < N; k++) if (g[k]) r = 3'(k);
    return r;
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic logic [2:0] first_from(input logic [3:0] req, input int rr);
    for (int i = 0; i < N; i++) begin
      if (req[(rr + i) % N]) return 3'((rr + i) % N);
    end
    return 3'd0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; dev_req = '0; dma_ack = 1'b0; mem_ack = 1'b0; ovr_clr = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  prev_gnt;
    logic        prev_dreq;
    logic [3:0]  applied_req;
    logic [2:0]  cur_owner;
    logic [2:0]  w;
    logic [2:0]  exp_order[5];
    int          rr_m;
    int          ngr;
    int          held;

    for (int k = 0; k < N; k++) adr_arr[k] = adr_of(k);
    dev_stb = 4'b0011;
    rst_n = 1'b0; dev_req = '0; dma_ack = 1'b0; mem_ack = 1'b0; ovr_clr = 1'b0;

    // ---------------- table-driven cycle vectors ----------------
    //              rst req     ack mem  gnt     dreq own   dack    stb
    vt.push_back(mk(0, 4'b0000, 0, 0,   4'b0000, 0, 3'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0001, 0, 0,   4'b0000, 1, 3'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0001, 0, 0,   4'b0000, 1, 3'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0001, 0, 0,   4'b0000, 1, 3'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0001, 1, 0,   4'b0001, 1, 3'd0, 4'b0000, 1));
    vt.push_back(mk(1, 4'b0001, 1, 1,   4'b0001, 1, 3'd0, 4'b0001, 1));
    vt.push_back(mk(1, 4'b0000, 1, 1,   4'b0000, 0, 3'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0000, 0, 0,   4'b0000, 0, 3'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0011, 0, 0,   4'b0000, 1, 3'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0011, 1, 1,   4'b0010, 1, 3'd1, 4'b0010, 1));
    vt.push_back(mk(1, 4'b0011, 1, 0,   4'b0010, 1, 3'd1, 4'b0000, 1));
    vt.push_back(mk(1, 4'b0001, 1, 0,   4'b0000, 0, 3'd1, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0001, 1, 1,   4'b0000, 0, 3'd1, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0001, 0, 0,   4'b0000, 0, 3'd1, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0100, 0, 0,   4'b0000, 1, 3'd1, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0000, 0, 0,   4'b0000, 0, 3'd1, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0000, 0, 0,   4'b0000, 0, 3'd1, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0101, 0, 0,   4'b0000, 1, 3'd1, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0101, 1, 0,   4'b0100, 1, 3'd2, 4'b0000, 0));
    vt.push_back(mk(0, 4'b0101, 1, 1,   4'b0000, 0, 3'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0000, 0, 0,   4'b0000, 0, 3'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0011, 0, 0,   4'b0000, 1, 3'd0, 4'b0000, 0));
    vt.push_back(mk(1, 4'b0011, 1, 0,   4'b0001, 1, 3'd0, 4'b0000, 1));

    for (int i = 0; i < vt.size(); i++) begin
      rst_n = vt[i].rst_n; dev_req = vt[i].req; dma_ack = vt[i].ack; mem_ack = vt[i].mem;
      step();
      check($sformatf("v%0d_gnt", i), 32'(dev_gnt), 32'(vt[i].e_gnt));
      check($sformatf("v%0d_dma_req", i), 32'(dma_req), 32'(vt[i].e_dreq));
      check($sformatf("v%0d_owner", i), 32'(owner), 32'(vt[i].e_own));
      check($sformatf("v%0d_overrun", i), 32'(overrun), 32'd0);
      check($sformatf("v%0d_dev_ack", i), 32'(dev_ack), 32'(vt[i].e_dack));
      check($sformatf("v%0d_dma_stb", i), 32'(dma_stb), 32'(vt[i].e_stb));
      check($sformatf("v%0d_adr", i), 32'(dma_adr18),
            (vt[i].e_gnt != 0) ? 32'(adr_of(int'(vt[i].e_own))) : 32'd0);
    end

    // ---------------- tenure overrun: device 0 keeps its grant ----------------
    mem_ack = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      adr_arr[0] = 18'($urandom);
      step();
      check("ovr_gnt_kept", 32'(dev_gnt), 32'b0001);
      check("ovr_adr_track", 32'(dma_adr18), 32'(adr_arr[0]));
      if (k == 15) check("ovr_before_limit", 32'(overrun), 32'd0);
      if (k == 16) check("ovr_at_limit", 32'(overrun), 32'd1);
    end
    adr_arr[0] = adr_of(0);
    ovr_clr = 1'b1;
    step();
    check("ovr_cleared", 32'(overrun), 32'd0);
    ovr_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ovr_stays_clear", 32'(overrun), 32'd0);
      check("ovr_gnt_still", 32'(dev_gnt), 32'b0001);
    end

    // Board drops dma_ack mid-grant while ovr_clr is pulsed: set must win.
    ovr_clr = 1'b1; dma_ack = 1'b0;
    step();
    check("fault_gnt", 32'(dev_gnt), 32'd0);
    check("fault_overrun", 32'(overrun), 32'd1);
    check("fault_state_rel", 32'(dbg_state), 32'd3);
    ovr_clr = 1'b0;
    step();
    check("fault_state_idle", 32'(dbg_state), 32'd0);
    check("fault_ovr_sticky", 32'(overrun), 32'd1);

    // ---------------- round robin with all four requesting ----------------
    do_reset();
    check("rr_reset_ovr", 32'(overrun), 32'd0);
    exp_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    dev_req = 4'hF; ngr = 0; held = 0; prev_gnt = '0;
    for (int c = 0; c < 300 && ngr < 5; c++) begin
      step();
      dma_ack = dma_req;
      if (dev_gnt != 0 && prev_gnt == 0) begin
        check("rr_order", 32'(gidx(dev_gnt)), 32'(exp_order[ngr]));
        ngr++;
        held = 0;
      end
      dev_req = 4'hF;
      if (dev_gnt != 0) begin
        held++;
        if (held == 4) dev_req = 4'hF & ~dev_gnt;
      end
      prev_gnt = dev_gnt;
    end
    check("rr_grants_seen", 32'(ngr), 32'd5);

    // ---------------- randomized run against the grant-order model ----------------
    do_reset();
    rr_m = 0; prev_gnt = '0; prev_dreq = 1'b0; applied_req = '0; cur_owner = '0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      if (dma_req && !prev_dreq) exp_q.push_back(first_from(applied_req, rr_m));
      if (!dma_req && prev_dreq && dev_gnt == 0 && prev_gnt == 0) begin
        if (exp_q.size() == 0) check("abort_unexpected", 32'd1, 32'd0);
        else void'(exp_q.pop_front());
      end
      if (dev_gnt != 0 && prev_gnt == 0) begin
        if (exp_q.size() == 0) check("grant_unexpected", 32'd1, 32'd0);
        else begin
          w = exp_q.pop_front();
          check("grant_winner", 32'(dev_gnt), 32'(onehot(w)));
          cur_owner = w;
        end
      end
      if (dev_gnt == 0 && prev_gnt != 0) rr_m = (int'(cur_owner) + 1) % N;
      if (dev_gnt != 0) check("rand_owner", 32'(owner), 32'(cur_owner));
      check("gnt_onehot", 32'($countones(dev_gnt) <= 1), 32'd1);
      prev_gnt = dev_gnt;
      prev_dreq = dma_req;

      if (dma_req && !dma_ack && $urandom_range(0, 1) == 1) dma_ack = 1'b1;
      else if (!dma_req && dma_ack && $urandom_range(0, 1) == 1) dma_ack = 1'b0;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 5) == 0) dev_req[k] = ~dev_req[k];
        adr_arr[k] = 18'($urandom);
      end
      dev_stb = 4'($urandom);
      mem_ack = 1'($urandom);
      applied_req = dev_req;
      #1;
      if (dev_gnt != 0) begin
        check("rand_adr", 32'(dma_adr18), 32'(adr_arr[cur_owner]));
        check("rand_stb", 32'(dma_stb), 32'(dev_stb[cur_owner]));
        check("rand_dack", 32'(dev_ack), mem_ack ? 32'(onehot(cur_owner)) : 32'd0);
      end else begin
        check("rand_idle_adr", 32'(dma_adr18), 32'd0);
        check("rand_idle_stb", 32'(dma_stb), 32'd0);
        check("rand_idle_dack", 32'(dev_ack), 32'd0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
